neuron_scheduler: RTL and testbench
===================================

NEURON_SCHEDULER -- requirements
Module: neuron_scheduler

Interface
REQ-001 SHALL have parameter NUM_NEURONS, default 256, neurons sequenced per timestep.
REQ-002 SHALL have parameter NUM_AXONS, default 256, axon count and spike/connection vector width.
REQ-003 SHALL have parameters POTENTIAL_WIDTH / THRESHOLD_WIDTH / LEAK_WIDTH, default 9 each, signed widths; WEIGHT_WIDTH, default 2, signed.
REQ-004 SHALL have ports wb_clk_i in 1 (single clock; all logic on rising edge) and wb_rst_ni in 1 (asynchronous, active-low reset).
REQ-005 SHALL have start_i in 1, one-cycle pulse beginning a timestep.
REQ-006 SHALL have spikes_i in NUM_AXONS (input spikes) and axon_type_i in NUM_AXONS (0 selects weight 0, 1 selects weight 1), both sampled on accepted start.
REQ-007 SHALL have param_req_o out 1, param_addr_o out $clog2(NUM_NEURONS), and param_ack_i in 1: parameter fetch handshake.
REQ-008 SHALL have connections_i in NUM_AXONS, leak_i, weights_0_i, weights_1_i, positive_threshold_i, negative_threshold_i, reset_potential_i, current_potential_i (signed, widths per REQ-003), and reset_mode_i in 1: parameter fields, valid only when param_ack_i=1.
REQ-009 SHALL have wr_en_o out 1, wr_addr_o out $clog2(NUM_NEURONS), wr_potential_o out POTENTIAL_WIDTH: potential write-back.
REQ-010 SHALL have spike_valid_o out 1 and spike_neuron_o out $clog2(NUM_NEURONS): output spike event.
REQ-011 SHALL have busy_o out 1 and done_o out 1 (one-cycle pulse at end of timestep).

Function
REQ-012 SHALL implement FSM IDLE -> FETCH -> INTEGRATE -> LEAK -> FIRE -> WRITE -> (FETCH for next neuron | DONE) -> IDLE.
REQ-013 IDLE: start_i=1 SHALL latch spikes_i/axon_type_i, clear neuron index to 0, enter FETCH; start_i while not IDLE SHALL be ignored.
REQ-014 FETCH: param_req_o SHALL be 1 with param_addr_o = neuron index, held until param_ack_i=1; on that cycle all parameter inputs SHALL be registered, req dropped, INTEGRATE entered. param_ack_i outside FETCH SHALL be ignored.
REQ-015 INTEGRATE: exactly NUM_AXONS cycles, axon j at cycle j; if spike[j] & connection[j], acc += (type[j] ? w1 : w0), sign-extended; acc initialised to current potential.
REQ-016 Every addition SHALL saturate to signed POTENTIAL_WIDTH range (default -256..255), no wrap-around.
REQ-017 LEAK: one cycle, acc = sat(acc + leak).
REQ-018 FIRE: one cycle; if acc >= positive_threshold: spike_valid_o=1 for that cycle, spike_neuron_o = index, acc = reset_mode 0 ? reset_potential : sat(acc - positive_threshold).
REQ-019 FIRE: else if acc < negative_threshold: no spike, acc = reset_mode 0 ? reset_potential : negative_threshold; otherwise acc unchanged.
REQ-020 WRITE: one cycle, wr_en_o=1, wr_addr_o = index, wr_potential_o = acc; write always accepted.
REQ-021 After WRITE: index = NUM_NEURONS-1 -> DONE, else index+1 -> FETCH.
REQ-022 DONE: one cycle, done_o=1, then IDLE; start_i in DONE ignored.
REQ-023 busy_o SHALL be 1 in every state except IDLE.
REQ-024 Per-neuron latency SHALL be (FETCH wait cycles + 1) + NUM_AXONS + 3 cycles.
REQ-025 wr_en_o, spike_valid_o, done_o SHALL be registered single-cycle pulses; addr outputs SHALL hold last value otherwise.

Reset
REQ-026 wb_rst_ni=0 SHALL asynchronously force IDLE and all outputs, index, accumulator and latched vectors to 0, at any state including mid-timestep.
REQ-027 After reset release, no write or spike SHALL be emitted for the aborted timestep; next start_i begins at neuron 0.

Verification
REQ-028 Neuron 0: pot 0, spikes/conn on axons 0..9, type 0, w0=1, leak 0, pos_thr 5, mode 0, reset 0 -> one spike_valid_o, neuron 0, wr_potential_o 0.
REQ-029 Saturation: pot 250, 20 connected spikes w0=1, leak 0, pos_thr 255 -> wr_potential_o 255, spike emitted, mode 1 -> written 0.
REQ-030 Negative: pot -250, 20 spikes w1=-2 (type 1), neg_thr -200, mode 1 -> no spike, wr_potential_o -200.
REQ-031 Handshake: param_ack_i delayed 5 cycles for each neuron, NUM_NEURONS=4 -> 4 writes at addr 0..3 in order, done_o once, total cycles match REQ-024.
REQ-032 start_i pulsed while busy and param_ack_i pulsed in INTEGRATE -> no effect on sequence or outputs.
REQ-033 wb_rst_ni low during INTEGRATE of neuron 2 -> outputs 0 immediately, no wr_en_o, next start restarts at address 0.

Source files
------------

// File: rtl/neuron_scheduler.sv
// neuron_scheduler: sequences one leaky integrate-and-fire timestep over all neurons.
// For each neuron it fetches parameters over a req/ack handshake and then integrates the
// latched spike vector one axon per cycle. It then applies leak, evaluates the thresholds,
// and writes the updated potential back.
// All arithmetic on the potential saturates to the signed POTENTIAL_WIDTH range.
//
// Ports
//   wb_clk_i, wb_rst_ni      clock (rising edge), asynchronous active-low reset
//   start_i                  one-cycle pulse starting a timestep (only honoured in IDLE)
//   spikes_i, axon_type_i    per-axon spike and weight-select vectors, latched on start
//   param_req_o/addr_o/ack_i parameter fetch handshake for the current neuron
//   connections_i .. reset_mode_i  parameter fields, valid while param_ack_i=1
//   wr_en_o/addr_o/potential_o     potential write-back pulse
//   spike_valid_o/neuron_o   output spike event pulse
//   busy_o, done_o           not-idle flag, end-of-timestep pulse
module neuron_scheduler #(
  parameter int NUM_NEURONS     = 256,
  parameter int NUM_AXONS       = 256,
  parameter int POTENTIAL_WIDTH = 9,
  parameter int THRESHOLD_WIDTH = 9,
  parameter int LEAK_WIDTH      = 9,
  parameter int WEIGHT_WIDTH    = 2,
  localparam int NW = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1
) (
  input  logic                              wb_clk_i,
  input  logic                              wb_rst_ni,
  input  logic                              start_i,
  input  logic [NUM_AXONS-1:0]              spikes_i,
  input  logic [NUM_AXONS-1:0]              axon_type_i,
  output logic                              param_req_o,
  output logic [NW-1:0]                     param_addr_o,
  input  logic                              param_ack_i,
  input  logic [NUM_AXONS-1:0]              connections_i,
  input  logic signed [LEAK_WIDTH-1:0]      leak_i,
  input  logic signed [WEIGHT_WIDTH-1:0]    weights_0_i,
  input  logic signed [WEIGHT_WIDTH-1:0]    weights_1_i,
  input  logic signed [THRESHOLD_WIDTH-1:0] positive_threshold_i,
  input  logic signed [THRESHOLD_WIDTH-1:0] negative_threshold_i,
  input  logic signed [POTENTIAL_WIDTH-1:0] reset_potential_i,
  input  logic signed [POTENTIAL_WIDTH-1:0] current_potential_i,
  input  logic                              reset_mode_i,
  output logic                              wr_en_o,
  output logic [NW-1:0]                     wr_addr_o,
  output logic signed [POTENTIAL_WIDTH-1:0] wr_potential_o,
  output logic                              spike_valid_o,
  output logic [NW-1:0]                     spike_neuron_o,
  output logic                              busy_o,
  output logic                              done_o
);

  localparam int AW = (NUM_AXONS > 1) ? $clog2(NUM_AXONS) : 1;
  localparam int PW = POTENTIAL_WIDTH;
  // Internal arithmetic width: wide enough that no sum or difference of two operands overflows.
  localparam int W1 = (PW > THRESHOLD_WIDTH) ? PW : THRESHOLD_WIDTH;
  localparam int W2 = (W1 > LEAK_WIDTH) ? W1 : LEAK_WIDTH;
  localparam int EW = ((W2 > WEIGHT_WIDTH) ? W2 : WEIGHT_WIDTH) + 2;
  localparam logic signed [EW-1:0] POT_MAX = EW'(2 ** (PW - 1) - 1);
  localparam logic signed [EW-1:0] POT_MIN = EW'(-(2 ** (PW - 1)));

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_INTEGRATE, S_LEAK, S_FIRE, S_WRITE, S_DONE
  } state_t;

  state_t state, state_next;

  logic [NW-1:0]                     idx;
  logic [AW-1:0]                     axon;
  logic [NUM_AXONS-1:0]              spikes_q, types_q, conn_q;
  logic signed [LEAK_WIDTH-1:0]      leak_q;
  logic signed [WEIGHT_WIDTH-1:0]    w0_q, w1_q;
  logic signed [THRESHOLD_WIDTH-1:0] pos_thr_q, neg_thr_q;
  logic signed [PW-1:0]              reset_pot_q, acc;
  logic                              reset_mode_q;

  logic                              last_neuron, last_axon, leak_fire;
  logic signed [WEIGHT_WIDTH-1:0]    weight_sel;
  logic signed [PW-1:0]              integ_sum, leak_sum, fire_sub, neg_sat, fire_result;

  function automatic logic signed [PW-1:0] sat(input logic signed [EW-1:0] v);
    if (v > POT_MAX)      return PW'(POT_MAX);
    else if (v < POT_MIN) return PW'(POT_MIN);
    else                  return PW'(v);
  endfunction

  assign last_neuron  = (idx == NW'(NUM_NEURONS - 1));
  assign last_axon    = (axon == AW'(NUM_AXONS - 1));
  assign param_addr_o = idx;

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) state <= S_IDLE;
    else            state <= state_next;
  end

  // NOTE: every signal assigned in a combinational block gets a default first so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next  = state;
    param_req_o = 1'b0;
    busy_o      = (state != S_IDLE);
    case (state)
      S_IDLE:      if (start_i) state_next = S_FETCH;
      S_FETCH: begin
        param_req_o = 1'b1;
        if (param_ack_i) state_next = S_INTEGRATE;
      end
      S_INTEGRATE: if (last_axon) state_next = S_LEAK;
      S_LEAK:      state_next = S_FIRE;
      S_FIRE:      state_next = S_WRITE;
      S_WRITE:     state_next = last_neuron ? S_DONE : S_FETCH;
      S_DONE:      state_next = S_IDLE;
      default:     state_next = S_IDLE;
    endcase
  end

  always_comb begin
    weight_sel = types_q[axon] ? w1_q : w0_q;
    integ_sum  = sat(EW'(acc) + EW'(weight_sel));
    leak_sum   = sat(EW'(acc) + EW'(leak_q));
    leak_fire  = (EW'(leak_sum) >= EW'(pos_thr_q));
    fire_sub   = sat(EW'(acc) - EW'(pos_thr_q));
    neg_sat    = sat(EW'(neg_thr_q));
    // In FIRE the registered spike flag is the threshold decision taken on the leaked value
    // now held in acc, so it selects the fire branch directly.
    fire_result = acc;
    if (spike_valid_o)
      fire_result = reset_mode_q ? fire_sub : reset_pot_q;
    else if (EW'(acc) < EW'(neg_thr_q))
      fire_result = reset_mode_q ? neg_sat : reset_pot_q;
  end

  // NOTE: the latched spike/type/connection vectors are reset along with everything else,
  // so an aborted timestep leaves no stale state behind.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      idx            <= '0;
      axon           <= '0;
      spikes_q       <= '0;
      types_q        <= '0;
      conn_q         <= '0;
      leak_q         <= '0;
      w0_q           <= '0;
      w1_q           <= '0;
      pos_thr_q      <= '0;
      neg_thr_q      <= '0;
      reset_pot_q    <= '0;
      reset_mode_q   <= 1'b0;
      acc            <= '0;
      wr_en_o        <= 1'b0;
      wr_addr_o      <= '0;
      wr_potential_o <= '0;
      spike_valid_o  <= 1'b0;
      spike_neuron_o <= '0;
      done_o         <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every branch sees the pre-edge values.
      wr_en_o       <= 1'b0;
      spike_valid_o <= 1'b0;
      done_o        <= 1'b0;
      case (state)
        S_IDLE: if (start_i) begin
          spikes_q <= spikes_i;
          types_q  <= axon_type_i;
          idx      <= '0;
        end
        S_FETCH: if (param_ack_i) begin
          conn_q       <= connections_i;
          leak_q       <= leak_i;
          w0_q         <= weights_0_i;
          w1_q         <= weights_1_i;
          pos_thr_q    <= positive_threshold_i;
          neg_thr_q    <= negative_threshold_i;
          reset_pot_q  <= reset_potential_i;
          reset_mode_q <= reset_mode_i;
          acc          <= current_potential_i;
          axon         <= '0;
        end
        S_INTEGRATE: begin
          if (spikes_q[axon] && conn_q[axon]) acc <= integ_sum;
          axon <= axon + AW'(1);
        end
        S_LEAK: begin
          acc           <= leak_sum;
          spike_valid_o <= leak_fire;
          if (leak_fire) spike_neuron_o <= idx;
        end
        S_FIRE: begin
          acc            <= fire_result;
          wr_en_o        <= 1'b1;
          wr_addr_o      <= idx;
          wr_potential_o <= fire_result;
        end
        S_WRITE: begin
          if (last_neuron) done_o <= 1'b1;
          else             idx    <= idx + NW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_neuron_scheduler.sv
// Testbench for neuron_scheduler (4 neurons, 32 axons). Directed timesteps are issued from
// the main process, which pushes the hand-computed expected spike/write/done events into a
// queue. An independent monitor pops and compares whenever the DUT pulses an output. A
// parameter responder answers fetches after a programmable delay.
module tb_neuron_scheduler;

  localparam int NN = 4;
  localparam int NA = 32;
  localparam int NW = 2;
  localparam int PW = 9;

  typedef struct {
    logic [NA-1:0] conn;
    int pot, leak, w0, w1, pos, neg, rpot;
    bit mode;
  } cfg_t;

  typedef enum int {EV_SPIKE, EV_WRITE, EV_DONE} ev_kind_t;
  typedef struct {
    ev_kind_t kind;
    int       addr;
    int       pot;
  } ev_t;

  logic                 clk, rst_n, start_i, param_req_o, param_ack_i, reset_mode_i;
  logic [NA-1:0]        spikes_i, axon_type_i, connections_i;
  logic [NW-1:0]        param_addr_o, wr_addr_o, spike_neuron_o;
  logic signed [8:0]    leak_i, positive_threshold_i, negative_threshold_i;
  logic signed [8:0]    reset_potential_i, current_potential_i, wr_potential_o;
  logic signed [1:0]    weights_0_i, weights_1_i;
  logic                 wr_en_o, spike_valid_o, busy_o, done_o;

  int   tests_run = 0;
  int   tests_failed = 0;
  int   cyc = 0;
  int   start_cyc = 0;
  int   ack_delay = 0;
  bit   stray_ack = 0;
  cfg_t cur [NN];
  ev_t  sb [$];

  neuron_scheduler #(
    .NUM_NEURONS(NN), .NUM_AXONS(NA), .POTENTIAL_WIDTH(PW),
    .THRESHOLD_WIDTH(9), .LEAK_WIDTH(9), .WEIGHT_WIDTH(2)
  ) dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n), .start_i(start_i),
    .spikes_i(spikes_i), .axon_type_i(axon_type_i),
    .param_req_o(param_req_o), .param_addr_o(param_addr_o), .param_ack_i(param_ack_i),
    .connections_i(connections_i), .leak_i(leak_i),
    .weights_0_i(weights_0_i), .weights_1_i(weights_1_i),
    .positive_threshold_i(positive_threshold_i), .negative_threshold_i(negative_threshold_i),
    .reset_potential_i(reset_potential_i), .current_potential_i(current_potential_i),
    .reset_mode_i(reset_mode_i),
    .wr_en_o(wr_en_o), .wr_addr_o(wr_addr_o), .wr_potential_o(wr_potential_o),
    .spike_valid_o(spike_valid_o), .spike_neuron_o(spike_neuron_o),
    .busy_o(busy_o), .done_o(done_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    tests_run++;
    if (act != exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic cfg_t mk(input logic [NA-1:0] conn, input int pot, leak, w0, w1,
                              pos, neg, rpot, input bit mode);
    cfg_t c;
    c.conn = conn; c.pot = pot; c.leak = leak; c.w0 = w0; c.w1 = w1;
    c.pos = pos; c.neg = neg; c.rpot = rpot; c.mode = mode;
    return c;
  endfunction

  function automatic cfg_t junk();
    return mk($urandom, $urandom_range(0, 511) - 256, $urandom_range(0, 511) - 256,
              $urandom_range(0, 3) - 2, $urandom_range(0, 3) - 2,
              $urandom_range(0, 511) - 256, $urandom_range(0, 511) - 256,
              $urandom_range(0, 511) - 256, 1'($urandom));
  endfunction

  task automatic drive_fields(input cfg_t c);
    connections_i        = c.conn;
    current_potential_i  = 9'(c.pot);
    leak_i               = 9'(c.leak);
    weights_0_i          = 2'(c.w0);
    weights_1_i          = 2'(c.w1);
    positive_threshold_i = 9'(c.pos);
    negative_threshold_i = 9'(c.neg);
    reset_potential_i    = 9'(c.rpot);
    reset_mode_i         = c.mode;
  endtask

  // Parameter responder: acks a fetch after ack_delay wait cycles; fields carry junk otherwise.
  int ack_cnt = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      param_ack_i = 1'b0;
      ack_cnt = 0;
      drive_fields(junk());
    end else if (param_req_o) begin
      if (ack_cnt == ack_delay) begin
        param_ack_i = 1'b1;
        drive_fields(cur[param_addr_o]);
      end else begin
        param_ack_i = 1'b0;
        drive_fields(junk());
      end
      ack_cnt++;
    end else begin
      ack_cnt = 0;
      param_ack_i = stray_ack && (cyc % 3 == 0);
      drive_fields(junk());
    end
  end

  // Monitor: every output pulse must match the head of the expected-event queue.
  always @(negedge clk) begin
    ev_t e;
    if (rst_n) begin
      if (spike_valid_o) begin
        if (sb.size() == 0) check("spike_unexpected", 1, 0);
        else begin
          e = sb.pop_front();
          check("spike_kind", EV_SPIKE, int'(e.kind));
          check("spike_neuron", int'(spike_neuron_o), e.addr);
        end
      end
      if (wr_en_o) begin
        if (sb.size() == 0) check("write_unexpected", 1, 0);
        else begin
          e = sb.pop_front();
          check("write_kind", EV_WRITE, int'(e.kind));
          check("write_addr", int'(wr_addr_o), e.addr);
          check("write_potential", int'(wr_potential_o), e.pot);
        end
      end
      if (done_o) begin
        if (sb.size() == 0) check("done_unexpected", 1, 0);
        else begin
          e = sb.pop_front();
          check("done_kind", EV_DONE, int'(e.kind));
        end
      end
    end
  end

  function automatic void exp_spike(input int n);
    ev_t e; e.kind = EV_SPIKE; e.addr = n; e.pot = 0; sb.push_back(e);
  endfunction
  function automatic void exp_write(input int a, input int p);
    ev_t e; e.kind = EV_WRITE; e.addr = a; e.pot = p; sb.push_back(e);
  endfunction
  function automatic void exp_done();
    ev_t e; e.kind = EV_DONE; e.addr = 0; e.pot = 0; sb.push_back(e);
  endfunction

  // Timestep 1: spikes on axons 0..19 and 25; axons 10..19 select weight 1.
  localparam logic [NA-1:0] TS1_SPK = 32'h020F_FFFF;
  localparam logic [NA-1:0] TS1_TYP = 32'h000F_FC00;
  task automatic load_ts1();
    cur[0] = mk(32'h1000_03FF,    0,  0,  1, -1,   5, -100, 0, 1'b0); // 10 -> fires, reset 0
    cur[1] = mk(32'h000F_FFFF,  250,  0,  1,  1, 255, -256, 7, 1'b1); // sat 255 -> fires, 0
    cur[2] = mk(32'h000F_FFFF, -250,  0, -2, -2, 100, -200, 3, 1'b1); // sat -256 -> -200
    cur[3] = mk(32'h000F_FC00,   50, -3,  1, -1, 100,  -50, 9, 1'b0); // 40, leak -> 37
  endtask
  function automatic void exp_ts1();
    exp_spike(0); exp_write(0, 0);
    exp_spike(1); exp_write(1, 0);
    exp_write(2, -200);
    exp_write(3, 37);
    exp_done();
  endfunction

  // Timestep 2: spikes on axons 0..7; axons 4..7 select weight 1.
  localparam logic [NA-1:0] TS2_SPK = 32'h0000_00FF;
  localparam logic [NA-1:0] TS2_TYP = 32'h0000_00F0;
  task automatic load_ts2();
    cur[0] = mk(32'h0000_00FF,   20,    0,  1, -2,  10, -100,  5, 1'b1); // 16 -> fires, 6
    cur[1] = mk(32'h0000_000F,  -10,   -5, -2,  1, 100,  -20, -1, 1'b0); // -23 -> reset -1
    cur[2] = mk(32'h0000_0000, -250, -100,  1,  1,   0, -256,  4, 1'b1); // leak sat -256
    cur[3] = mk(32'h0000_00F0,    0,    1, -2,  1,   5,  -50,  2, 1'b0); // 5 == thr -> 2
  endtask

  task automatic start_ts(input logic [NA-1:0] spk, input logic [NA-1:0] typ);
    @(negedge clk);
    spikes_i = spk; axon_type_i = typ; start_i = 1'b1;
    @(posedge clk);
    #1 start_cyc = cyc;
    @(negedge clk);
    start_i = 1'b0; spikes_i = ~spk; axon_type_i = ~typ;
  endtask

  task automatic wait_done(input int exp_latency);
    bit got = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (done_o) begin got = 1; break; end
    end
    if (!got) check("done_timeout", 0, 1);
    else      check("timestep_latency", cyc - start_cyc, exp_latency);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_wr_en"}, int'(wr_en_o), 0);
    check({tag, "_spike_valid"}, int'(spike_valid_o), 0);
    check({tag, "_done"}, int'(done_o), 0);
    check({tag, "_busy"}, int'(busy_o), 0);
    check({tag, "_param_req"}, int'(param_req_o), 0);
    check({tag, "_param_addr"}, int'(param_addr_o), 0);
    check({tag, "_wr_addr"}, int'(wr_addr_o), 0);
    check({tag, "_wr_potential"}, int'(wr_potential_o), 0);
    check({tag, "_spike_neuron"}, int'(spike_neuron_o), 0);
  endtask

  initial begin
    bit hit;
    rst_n = 1'b0; start_i = 1'b0; spikes_i = '0; axon_type_i = '0;
    load_ts1();
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Timestep 1: 5 wait cycles per fetch.
    ack_delay = 5;
    load_ts1();
    exp_ts1();
    start_ts(TS1_SPK, TS1_TYP);
    wait_done(NN * ((5 + 1) + NA + 3));
    repeat (4) @(negedge clk);
    check("ts1_drained", sb.size(), 0);
    check("ts1_idle", int'(busy_o), 0);

    // Timestep 2: immediate ack, stray acks, start pulsed while busy and in DONE.
    ack_delay = 0;
    stray_ack = 1;
    load_ts2();
    exp_spike(0); exp_write(0, 6);
    exp_write(1, -1);
    exp_write(2, -256);
    exp_spike(3); exp_write(3, 2);
    exp_done();
    start_ts(TS2_SPK, TS2_TYP);
    repeat (10) @(negedge clk);
    spikes_i = '1; axon_type_i = '0; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    wait_done(NN * ((0 + 1) + NA + 3));
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    check("start_in_done_ignored", int'(busy_o), 0);
    stray_ack = 0;
    repeat (4) @(negedge clk);
    check("ts2_drained", sb.size(), 0);

    // Timestep 3: reset asserted during INTEGRATE of neuron 2.
    ack_delay = 2;
    load_ts1();
    exp_spike(0); exp_write(0, 0);
    exp_spike(1); exp_write(1, 0);
    start_ts(TS1_SPK, TS1_TYP);
    hit = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (busy_o && !param_req_o && param_addr_o == 2'd2) begin hit = 1; break; end
    end
    check("reach_neuron2_integrate", int'(hit), 1);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_outputs_zero("midrun_reset");
    check("pre_reset_events_seen", sb.size(), 0);
    sb.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("post_reset_idle", int'(busy_o), 0);

    // Timestep 4: fresh start after the abort begins again at neuron 0.
    load_ts1();
    exp_ts1();
    start_ts(TS1_SPK, TS1_TYP);
    wait_done(NN * ((2 + 1) + NA + 3));
    repeat (4) @(negedge clk);
    check("ts4_drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, got cycle %0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
